// File: rtl/thread_issue_scheduler.sv
//==============================================================================
// Module   : thread_issue_scheduler
// Purpose  : Per-cycle issue scheduler for a multithreaded 5-stage pipeline.
//            Each cycle picks one thread round-robin among threads that hold a
//            decoded instruction with no register hazard. A per-thread
//            register scoreboard marks destinations busy at issue and frees
//            them on write-back.
// Ports    :
//    clk                 clock; all state updates on the rising edge
//    reset               synchronous, active-high reset
//    stall               downstream cannot accept an issue this cycle
//    thread_ready        bit t: thread t has a valid decoded instruction
//    src_a / src_b / dst per-thread register indices, thread t in slice t
//    dst_valid           bit t: thread t's instruction writes dst
//    wb_flag             write-back is writing a register this cycle
//    wb_reg_index        register being written back
//    wb_thread_index     thread being written back
//    issue_valid         registered; an instruction issued
//    issue_thread_index  registered; index of the issued thread (holds when idle)
//    issue_grant         registered; one-hot grant, zero when issue_valid=0
//    thread_idle         registered; bit t=1 when thread t has no busy register
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module thread_issue_scheduler #(
   parameter int NUM_THREADS       = 8,
   parameter int THREAD_INDEX_BITS = 3,
   parameter int REG_INDEX_BITS    = 5
) (
   input  logic                                   clk,
   input  logic                                   reset,
   input  logic                                   stall,
   input  logic [NUM_THREADS-1:0]                 thread_ready,
   input  logic [NUM_THREADS*REG_INDEX_BITS-1:0]  src_a,
   input  logic [NUM_THREADS*REG_INDEX_BITS-1:0]  src_b,
   input  logic [NUM_THREADS*REG_INDEX_BITS-1:0]  dst,
   input  logic [NUM_THREADS-1:0]                 dst_valid,
   input  logic                                   wb_flag,
   input  logic [REG_INDEX_BITS-1:0]              wb_reg_index,
   input  logic [THREAD_INDEX_BITS-1:0]           wb_thread_index,
   output logic                                   issue_valid,
   output logic [THREAD_INDEX_BITS-1:0]           issue_thread_index,
   output logic [NUM_THREADS-1:0]                 issue_grant,
   output logic [NUM_THREADS-1:0]                 thread_idle
);

   localparam int c_NUM_REGS = 2**REG_INDEX_BITS;
   localparam logic [c_NUM_REGS-1:0]  c_REG_ONE    = {{(c_NUM_REGS-1){1'b0}}, 1'b1};
   localparam logic [NUM_THREADS-1:0] c_THREAD_ONE = {{(NUM_THREADS-1){1'b0}}, 1'b1};

   // Scoreboard and round-robin pointer
   logic [c_NUM_REGS-1:0]        r_busy [NUM_THREADS];
   logic [THREAD_INDEX_BITS-1:0] r_rr_ptr;

   // Combinational decision signals
   logic [c_NUM_REGS-1:0]        w_eff_busy  [NUM_THREADS];
   logic [c_NUM_REGS-1:0]        w_busy_next [NUM_THREADS];
   logic [NUM_THREADS-1:0]       w_eligible;
   logic [NUM_THREADS-1:0]       w_idle_next;
   logic                         w_win_valid;
   logic [THREAD_INDEX_BITS-1:0] w_win_idx;
   logic [THREAD_INDEX_BITS-1:0] w_cand;
   logic                         w_issue;

   assign w_issue = w_win_valid & ~stall;

   //---------------------------------------------------------------------------
   // Per-thread hazard check and scoreboard next state
   //---------------------------------------------------------------------------
   generate
      for (genvar t = 0; t < NUM_THREADS; t++) begin : g_thread
         logic [REG_INDEX_BITS-1:0] w_sa;
         logic [REG_INDEX_BITS-1:0] w_sb;
         logic [REG_INDEX_BITS-1:0] w_d;
         logic [c_NUM_REGS-1:0]     w_clr_mask;
         logic [c_NUM_REGS-1:0]     w_set_mask;

         assign w_sa = src_a[t*REG_INDEX_BITS +: REG_INDEX_BITS];
         assign w_sb = src_b[t*REG_INDEX_BITS +: REG_INDEX_BITS];
         assign w_d  = dst  [t*REG_INDEX_BITS +: REG_INDEX_BITS];

         // Register being written back this cycle counts as free (bypass)
         assign w_clr_mask = (wb_flag && (wb_thread_index == THREAD_INDEX_BITS'(t)))
                             ? (c_REG_ONE << wb_reg_index) : '0;

         assign w_eff_busy[t] = r_busy[t] & ~w_clr_mask;

         // Bit 0 of r_busy is never set, so r0 operands always pass
         assign w_eligible[t] = thread_ready[t]
                              & ~w_eff_busy[t][w_sa]
                              & ~w_eff_busy[t][w_sb]
                              & ~(dst_valid[t] & w_eff_busy[t][w_d]);

         assign w_set_mask = (w_issue && (w_win_idx == THREAD_INDEX_BITS'(t)) && dst_valid[t])
                             ? (c_REG_ONE << w_d) : '0;

         // Set is OR'ed in after the clear so a same-edge set wins;
         // r0 is masked so it can never become busy.
         assign w_busy_next[t] = ((r_busy[t] & ~w_clr_mask) | w_set_mask) & ~c_REG_ONE;

         assign w_idle_next[t] = ~|w_busy_next[t];
      end
   endgenerate

   //---------------------------------------------------------------------------
   // Round-robin arbiter: scan from r_rr_ptr upward. Walking the offsets from
   // highest to lowest lets the smallest offset overwrite the result last.
   // Wrap relies on NUM_THREADS == 2**THREAD_INDEX_BITS.
   //---------------------------------------------------------------------------
   always_comb begin
      w_win_valid = 1'b0;
      w_win_idx   = '0;
      w_cand      = '0;
      for (int k = NUM_THREADS - 1; k >= 0; k--) begin
         w_cand = r_rr_ptr + THREAD_INDEX_BITS'(k);
         if (w_eligible[w_cand]) begin
            w_win_valid = 1'b1;
            w_win_idx   = w_cand;
         end
      end
   end

   //---------------------------------------------------------------------------
   // State and registered outputs
   //---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int t = 0; t < NUM_THREADS; t++) begin
            r_busy[t] <= '0;
         end
         r_rr_ptr           <= '0;
         issue_valid        <= 1'b0;
         issue_thread_index <= '0;
         issue_grant        <= '0;
         thread_idle        <= '1;
      end else begin
         for (int t = 0; t < NUM_THREADS; t++) begin
            r_busy[t] <= w_busy_next[t];
         end
         if (w_issue) begin
            issue_valid        <= 1'b1;
            issue_thread_index <= w_win_idx;
            issue_grant        <= c_THREAD_ONE << w_win_idx;
            r_rr_ptr           <= w_win_idx + THREAD_INDEX_BITS'(1);
         end else begin
            // issue_thread_index and r_rr_ptr intentionally hold
            issue_valid <= 1'b0;
            issue_grant <= '0;
         end
         thread_idle <= w_idle_next;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_thread_issue_scheduler.sv
//==============================================================================
// Module   : tb_thread_issue_scheduler
// Purpose  : Self-checking bench for thread_issue_scheduler. A behavioural
//            scoreboard/arbiter model predicts every registered output each
//            cycle; directed scenarios add literal expectations.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_thread_issue_scheduler;

   localparam int NT = 8;
   localparam int TB = 3;
   localparam int RB = 5;
   localparam int NR = 32;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              reset;
   logic              stall;
   logic [NT-1:0]     thread_ready;
   logic [NT*RB-1:0]  src_a;
   logic [NT*RB-1:0]  src_b;
   logic [NT*RB-1:0]  dst;
   logic [NT-1:0]     dst_valid;
   logic              wb_flag;
   logic [RB-1:0]     wb_reg_index;
   logic [TB-1:0]     wb_thread_index;
   logic              issue_valid;
   logic [TB-1:0]     issue_thread_index;
   logic [NT-1:0]     issue_grant;
   logic [NT-1:0]     thread_idle;

   thread_issue_scheduler #(
      .NUM_THREADS       (NT),
      .THREAD_INDEX_BITS (TB),
      .REG_INDEX_BITS    (RB)
   ) dut (
      .clk                (clk),
      .reset              (reset),
      .stall              (stall),
      .thread_ready       (thread_ready),
      .src_a              (src_a),
      .src_b              (src_b),
      .dst                (dst),
      .dst_valid          (dst_valid),
      .wb_flag            (wb_flag),
      .wb_reg_index       (wb_reg_index),
      .wb_thread_index    (wb_thread_index),
      .issue_valid        (issue_valid),
      .issue_thread_index (issue_thread_index),
      .issue_grant        (issue_grant),
      .thread_idle        (thread_idle)
   );

   // Behavioural model state
   bit            m_busy [NT][NR];
   int            m_rr;
   bit            m_valid;
   int            m_idx;
   logic [NT-1:0] m_grant;
   logic [NT-1:0] m_idle;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit reg_free(int t, int r);
      if (r == 0) return 1'b1;
      if (!m_busy[t][r]) return 1'b1;
      return wb_flag && (int'(wb_thread_index) == t) && (int'(wb_reg_index) == r);
   endfunction

   function automatic bit can_issue(int t);
      int a, b, d;
      a = int'(src_a[t*RB +: RB]);
      b = int'(src_b[t*RB +: RB]);
      d = int'(dst[t*RB +: RB]);
      return thread_ready[t] && reg_free(t, a) && reg_free(t, b) &&
             (!dst_valid[t] || reg_free(t, d));
   endfunction

   // Predict the outputs the coming edge will produce from current inputs
   task automatic model_step();
      int win;
      if (reset) begin
         foreach (m_busy[t, r]) m_busy[t][r] = 1'b0;
         m_rr = 0; m_valid = 1'b0; m_idx = 0; m_grant = '0; m_idle = '1;
         return;
      end
      win = -1;
      if (!stall) begin
         for (int k = 0; k < NT; k++) begin
            if (win < 0 && can_issue((m_rr + k) % NT)) win = (m_rr + k) % NT;
         end
      end
      if (wb_flag) m_busy[int'(wb_thread_index)][int'(wb_reg_index)] = 1'b0;
      if (win >= 0) begin
         m_valid = 1'b1;
         m_idx   = win;
         m_grant = '0;
         m_grant[win] = 1'b1;
         m_rr    = (win + 1) % NT;
         if (dst_valid[win] && dst[win*RB +: RB] != 0)
            m_busy[win][int'(dst[win*RB +: RB])] = 1'b1;
      end else begin
         m_valid = 1'b0;
         m_grant = '0;
      end
      for (int t = 0; t < NT; t++) begin
         m_idle[t] = 1'b1;
         for (int r = 0; r < NR; r++) if (m_busy[t][r]) m_idle[t] = 1'b0;
      end
   endtask

   // One clock: predict, advance, compare every output against the model
   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
      chk("issue_valid", 32'(issue_valid), 32'(m_valid));
      chk("issue_thread_index", 32'(issue_thread_index), 32'(m_idx));
      chk("issue_grant", 32'(issue_grant), 32'(m_grant));
      chk("thread_idle", 32'(thread_idle), 32'(m_idle));
   endtask

   task automatic clear_inputs();
      reset = 1'b0; stall = 1'b0; thread_ready = '0;
      src_a = '0; src_b = '0; dst = '0; dst_valid = '0;
      wb_flag = 1'b0; wb_reg_index = '0; wb_thread_index = '0;
   endtask

   task automatic set_slot(int t, int a, int b, int d, bit dv);
      src_a[t*RB +: RB] = RB'(a);
      src_b[t*RB +: RB] = RB'(b);
      dst[t*RB +: RB]   = RB'(d);
      dst_valid[t]      = dv;
   endtask

   task automatic do_reset();
      clear_inputs();
      reset = 1'b1;
      cycle();
      reset = 1'b0;
   endtask

   initial begin
      clear_inputs();

      // Reset state with nothing ready
      do_reset();
      cycle();
      chk("rst_valid", 32'(issue_valid), 32'd0);
      chk("rst_grant", 32'(issue_grant), 32'd0);
      chk("rst_idle", 32'(thread_idle), 32'hFF);

      // Plain round robin over all threads
      thread_ready = 8'hFF;
      for (int i = 0; i < 10; i++) begin
         cycle();
         chk("rr_index", 32'(issue_thread_index), 32'(i % 8));
         chk("rr_grant", 32'(issue_grant), 32'(1) << (i % 8));
      end

      // RAW hazard on thread 2 and write-back bypass
      do_reset();
      thread_ready = 8'h04;
      set_slot(2, 0, 0, 5, 1'b1);
      cycle();
      chk("t2_first_index", 32'(issue_thread_index), 32'd2);
      chk("t2_idle_after_issue", 32'(thread_idle[2]), 32'd0);
      set_slot(2, 5, 0, 0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk("t2_blocked", 32'(issue_valid), 32'd0);
      end
      wb_flag = 1'b1; wb_thread_index = 3'd2; wb_reg_index = 5'd5;
      cycle();
      wb_flag = 1'b0;
      chk("t2_bypass_valid", 32'(issue_valid), 32'd1);
      chk("t2_bypass_index", 32'(issue_thread_index), 32'd2);
      chk("t2_idle_after_wb", 32'(thread_idle[2]), 32'd1);

      // Threads 1 and 3: thread 1 held off by busy r7
      do_reset();
      thread_ready = 8'h02;
      set_slot(1, 0, 0, 7, 1'b1);
      cycle();
      chk("t1_set_r7", 32'(issue_thread_index), 32'd1);
      thread_ready = 8'h0A;
      set_slot(1, 0, 7, 0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk("t3_only", 32'(issue_grant), 32'h08);
      end
      wb_flag = 1'b1; wb_thread_index = 3'd1; wb_reg_index = 5'd7;
      cycle();
      wb_flag = 1'b0;
      chk("t1_after_wb", 32'(issue_grant), 32'h02);

      // Stall with rr_ptr at 2
      do_reset();
      thread_ready = 8'hFF;
      cycle();
      cycle();
      thread_ready = 8'h0F;
      for (int t = 0; t < NT; t++) set_slot(t, 0, 0, 6, 1'b1);
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk("stall_valid", 32'(issue_valid), 32'd0);
         chk("stall_idle", 32'(thread_idle), 32'hFF);
      end
      stall = 1'b0;
      cycle();
      chk("after_stall_index", 32'(issue_thread_index), 32'd2);

      // Same-edge set and clear: set wins
      do_reset();
      thread_ready = 8'h10;
      set_slot(4, 0, 0, 9, 1'b1);
      wb_flag = 1'b1; wb_thread_index = 3'd4; wb_reg_index = 5'd9;
      cycle();
      wb_flag = 1'b0;
      chk("same_edge_index", 32'(issue_thread_index), 32'd4);
      chk("same_edge_idle4", 32'(thread_idle[4]), 32'd0);

      // Mid-stream reset with busy bits set
      reset = 1'b1;
      cycle();
      chk("mid_rst_valid", 32'(issue_valid), 32'd0);
      chk("mid_rst_grant", 32'(issue_grant), 32'd0);
      chk("mid_rst_idle", 32'(thread_idle), 32'hFF);
      chk("mid_rst_index", 32'(issue_thread_index), 32'd0);
      clear_inputs();
      thread_ready = 8'hFF;
      cycle();
      chk("restart_index", 32'(issue_thread_index), 32'd0);

      // Randomized traffic with a small register pool to provoke hazards
      for (int n = 0; n < 3000; n++) begin
         reset        = ($urandom_range(0, 99) == 0);
         stall        = ($urandom_range(0, 3) == 0);
         thread_ready = NT'($urandom);
         for (int t = 0; t < NT; t++)
            set_slot(t, $urandom_range(0, 3), $urandom_range(0, 3),
                     $urandom_range(0, 3), 1'($urandom_range(0, 1)));
         wb_flag         = 1'($urandom_range(0, 1));
         wb_thread_index = TB'($urandom_range(0, NT - 1));
         wb_reg_index    = RB'($urandom_range(0, 3));
         cycle();
         checks++;
         if ($countones(issue_grant) > 1) begin
            errors++;
            $display("FAIL grant_onehot: got %0h expected at most one bit", issue_grant);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/thread_issue_scheduler.md
Name: thread_issue_scheduler

Overview:
- Per-cycle issue scheduler for the multithreaded 5-stage pipeline.
- Selects one thread per cycle, round-robin, from threads that have a decoded instruction ready and no register hazard.
- Keeps a per-thread register scoreboard:
  - bits are set when an instruction with a destination issues;
  - bits are cleared by the write-back stage outputs (flag, reg index, thread index).
- Sits between the per-thread instruction buffers and the issue/execute stage.

Parameters:
- NUM_THREADS, 8, number of hardware threads.
- THREAD_INDEX_BITS, 3, width of a thread index; equals log2(NUM_THREADS).
- REG_INDEX_BITS, 5, width of a register index; 2**REG_INDEX_BITS registers per thread.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  downstream cannot accept an issue this cycle.
- thread_ready  input  NUM_THREADS  bit t: thread t has a valid decoded instruction.
- src_a  input  NUM_THREADS*REG_INDEX_BITS  source A register of thread t, in slice t.
- src_b  input  NUM_THREADS*REG_INDEX_BITS  source B register of thread t, in slice t.
- dst  input  NUM_THREADS*REG_INDEX_BITS  destination register of thread t, in slice t.
- dst_valid  input  NUM_THREADS  bit t: thread t's instruction writes dst.
- wb_flag  input  1  write-back stage is writing a register this cycle.
- wb_reg_index  input  REG_INDEX_BITS  register being written back.
- wb_thread_index  input  THREAD_INDEX_BITS  thread being written back.
- issue_valid  output  1  registered; an instruction is issued this cycle.
- issue_thread_index  output  THREAD_INDEX_BITS  registered; index of the issued thread.
- issue_grant  output  NUM_THREADS  registered; one-hot grant, all zero when issue_valid=0.
- thread_idle  output  NUM_THREADS  registered; bit t=1 when thread t has no busy register.

Behaviour:
- State:
  - busy[t][r]: NUM_THREADS x 2**REG_INDEX_BITS bits.
  - rr_ptr: THREAD_INDEX_BITS, the highest-priority thread.
- Reset (synchronous, whole block):
  - busy all 0, rr_ptr=0;
  - issue_valid=0, issue_thread_index=0, issue_grant=0;
  - thread_idle all 1.
  - Reset overrides every other input, including mid-operation.
- Register 0 is never busy:
  - sets and clears targeting r=0 are ignored;
  - hazard checks on r=0 always pass.
- Write-back bypass:
  - eff_busy[t][r] = busy[t][r] AND NOT (wb_flag AND wb_thread_index==t AND wb_reg_index==r).
  - A register being written back this cycle is treated as free.
- Eligibility of thread t:
  - thread_ready[t];
  - AND NOT eff_busy[t][src_a_t];
  - AND NOT eff_busy[t][src_b_t];
  - AND NOT (dst_valid[t] AND eff_busy[t][dst_t]), i.e. the WAW check.
- Arbitration (combinational):
  - first eligible thread scanning rr_ptr, rr_ptr+1, ..., wrapping modulo NUM_THREADS.
- At each edge with stall=0 and an eligible winner w:
  - issue_valid<=1, issue_thread_index<=w, issue_grant<=one-hot(w);
  - rr_ptr<=(w+1) mod NUM_THREADS (wraps 7->0);
  - if dst_valid[w] and dst_w!=0: busy[w][dst_w]<=1.
- At each edge with stall=1 or no eligible thread:
  - issue_valid<=0, issue_grant<=0;
  - issue_thread_index holds its previous value;
  - rr_ptr unchanged; no busy bit set.
- Write-back clear: applied every edge with wb_flag=1, independent of stall.
- Set and clear of the same busy[t][r] at the same edge: set wins, so the bit ends at 1.
- Clearing a bit that is already 0 is harmless.
- Latency:
  - decision made in cycle N appears on the outputs in cycle N+1;
  - the scoreboard update is visible to the eligibility check in cycle N+1.
- thread_idle[t] is registered: the NOR of the next-state busy[t][*].
- Exactly one or zero bits of issue_grant are set in any cycle.

Test Plan:
- Reset, then thread_ready=8'h00 -> issue_valid=0, issue_grant=0, thread_idle=8'hFF.
- thread_ready=8'hFF, all src/dst=0, dst_valid=0, 10 cycles -> issue_thread_index sequence 0,1,...,7,0,1; grant one-hot each cycle.
- Thread 2 only: issue with dst=5, dst_valid=1; next instruction src_a=5:
  - second instruction blocked while busy[2][5]=1;
  - thread_idle[2]=0 after the first issue;
  - wb_flag=1, wb_thread_index=2, wb_reg_index=5 in cycle K -> thread 2 issues in cycle K+1 (bypass); thread_idle[2]=1.
- Threads 1 and 3 ready; thread 1 src_b=7 busy -> only thread 3 issued, repeatedly; thread 1 granted the cycle after its r7 write-back.
- stall=1 for 3 cycles with thread_ready=8'h0F, rr_ptr=2:
  - issue_valid=0 throughout; no busy bits set;
  - after stall drops, the first grant is thread 2.
- Same-edge set and clear: thread 4 issues with dst=9 while wb clears thread 4 r9 -> busy[4][9]=1 afterwards.
- reset asserted mid-stream with busy bits set -> next cycle all outputs at reset values; grant restarts at thread 0.
